rob_mc: RTL and testbench

Parametrised multi-commit reorder buffer for the out-of-order core, replacing the single-commit ROB. It sits between the decoder (issue), the RS/ALU and LSB (write-back), and the regfile/instruction fetch (commit, redirect, flush). Depth and commit width are parameters. Occupancy is tracked by an explicit counter, so all DEPTH entries are usable. Mispredict flush and jalr redirect are registered, one-cycle pulses.

---
 rtl/rob_mc.sv | 139 +++++++++++++
 tb/tb_rob_mc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rob_mc.sv
// rob_mc: multi-commit reorder buffer with counter-tracked occupancy and registered flush/redirect pulses
module rob_mc #(
   parameter int DEPTH_LOG = 3,
   parameter int COMMIT_W  = 2
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          rdy_in,
   input  logic                          iss_valid,
   output logic                          iss_ready,
   output logic [DEPTH_LOG-1:0]          iss_id,
   input  logic [1:0]                    iss_type,
   input  logic [4:0]                    iss_rd,
   input  logic                          iss_done,
   input  logic [31:0]                   iss_result,
   input  logic                          iss_pred_jmp,
   input  logic [31:0]                   iss_alt_pc,
   input  logic                          wb0_valid,
   input  logic [DEPTH_LOG-1:0]          wb0_id,
   input  logic [31:0]                   wb0_val,
   input  logic                          wb0_redir_valid,
   input  logic [31:0]                   wb0_redir_pc,
   input  logic                          wb1_valid,
   input  logic [DEPTH_LOG-1:0]          wb1_id,
   input  logic [31:0]                   wb1_val,
   output logic [DEPTH_LOG-1:0]          head_id,
   output logic [DEPTH_LOG:0]            count,
   output logic [COMMIT_W-1:0]           cm_en,
   output logic [5*COMMIT_W-1:0]         cm_rd,
   output logic [32*COMMIT_W-1:0]        cm_val,
   output logic [DEPTH_LOG*COMMIT_W-1:0] cm_id,
   output logic                          redirect,
   output logic [31:0]                   redirect_pc,
   output logic                          flush,
   output logic [31:0]                   flush_pc,
   input  logic [DEPTH_LOG-1:0]          q_id_1,
   input  logic [DEPTH_LOG-1:0]          q_id_2,
   output logic                          q_avail_1,
   output logic                          q_avail_2,
   output logic [31:0]                   q_val_1,
   output logic [31:0]                   q_val_2
);
   localparam int DEPTH = 1 << DEPTH_LOG;
   logic [DEPTH-1:0] busy, done, pred;
   logic [1:0] typ [DEPTH];
   logic [4:0] rd [DEPTH];
   logic [31:0] val [DEPTH];
   logic [31:0] alt [DEPTH];
   logic [DEPTH_LOG-1:0] head, tail, h1;
   logic c0, c1, fire, mis, jr;
   logic [1:0] ncm;
   assign h1 = head + DEPTH_LOG'(1);
   assign head_id = head;
   assign iss_id = tail;
   assign iss_ready = count != DEPTH[DEPTH_LOG:0];
   assign fire = iss_valid && iss_ready && !flush;
   // commits are suppressed in the flush cycle so younger wrong-path entries never retire
   assign c0 = !flush && busy[head] && done[head];
   assign c1 = COMMIT_W == 2 && c0 && busy[h1] && done[h1] && !typ[head][0] && !typ[h1][0];
   assign ncm = {1'b0, c0} + {1'b0, c1};
   assign mis = c0 && typ[head] == 2'd1 && val[head][0] != pred[head];
   assign jr = c0 && typ[head] == 2'd3;
   genvar g;
   for (g = 0; g < COMMIT_W; g++) begin : lane
      logic [DEPTH_LOG-1:0] idx;
      assign idx = g == 0 ? head : h1;
      assign cm_en[g] = (g == 0 ? c0 : c1) && typ[idx][1];
      assign cm_rd[5*g +: 5] = rd[idx];
      assign cm_val[32*g +: 32] = val[idx];
      assign cm_id[DEPTH_LOG*g +: DEPTH_LOG] = idx;
   end
   // bypass priority mirrors the write-back winner: stored value, then wb1, then wb0
   always_comb begin
      q_avail_1 = done[q_id_1] || (wb0_valid && wb0_id == q_id_1) || (wb1_valid && wb1_id == q_id_1);
      q_avail_2 = done[q_id_2] || (wb0_valid && wb0_id == q_id_2) || (wb1_valid && wb1_id == q_id_2);
      q_val_1 = done[q_id_1] ? val[q_id_1] : (wb1_valid && wb1_id == q_id_1) ? wb1_val :
                (wb0_valid && wb0_id == q_id_1) ? wb0_val : val[q_id_1];
      q_val_2 = done[q_id_2] ? val[q_id_2] : (wb1_valid && wb1_id == q_id_2) ? wb1_val :
                (wb0_valid && wb0_id == q_id_2) ? wb0_val : val[q_id_2];
   end
   // entry state, pointers and the flush/redirect pulses; wb1 is written after wb0 so it wins
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         head <= '0;
         tail <= '0;
         count <= '0;
         busy <= '0;
         done <= '0;
         flush <= 1'b0;
         redirect <= 1'b0;
         flush_pc <= '0;
         redirect_pc <= '0;
      end else if (rdy_in) begin
         if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            busy <= '0;
            done <= '0;
            flush <= 1'b0;
            redirect <= 1'b0;
         end else begin
            if (fire) begin
               busy[tail] <= 1'b1;
               done[tail] <= iss_done;
               typ[tail] <= iss_type;
               rd[tail] <= iss_rd;
               val[tail] <= iss_result;
               pred[tail] <= iss_pred_jmp;
               alt[tail] <= iss_alt_pc;
            end
            if (wb0_valid && busy[wb0_id]) begin
               done[wb0_id] <= 1'b1;
               val[wb0_id] <= wb0_val;
               if (wb0_redir_valid) alt[wb0_id] <= wb0_redir_pc;
            end
            if (wb1_valid && busy[wb1_id]) begin
               done[wb1_id] <= 1'b1;
               val[wb1_id] <= wb1_val;
            end
            if (c0) begin
               busy[head] <= 1'b0;
               done[head] <= 1'b0;
            end
            if (c1) begin
               busy[h1] <= 1'b0;
               done[h1] <= 1'b0;
            end
            flush <= mis;
            redirect <= jr;
            if (mis) flush_pc <= alt[head];
            if (jr) redirect_pc <= alt[head];
            head <= head + DEPTH_LOG'(ncm);
            tail <= tail + DEPTH_LOG'(fire);
            count <= count + (DEPTH_LOG+1)'(fire) - (DEPTH_LOG+1)'(ncm);
         end
      end
   end
endmodule

// File: tb/tb_rob_mc.sv
// tb_rob_mc: directed vector table plus hand sequences for flush, jalr, collision and stall
module tb_rob_mc;
   logic clk_in = 0, rst_in, rdy_in;
   logic iss_valid, iss_ready, iss_done, iss_pred_jmp;
   logic [2:0] iss_id, head_id, wb0_id, wb1_id, q_id_1, q_id_2;
   logic [1:0] iss_type, cm_en;
   logic [4:0] iss_rd;
   logic [31:0] iss_result, iss_alt_pc, wb0_val, wb0_redir_pc, wb1_val;
   logic wb0_valid, wb0_redir_valid, wb1_valid;
   logic [3:0] count;
   logic [9:0] cm_rd;
   logic [63:0] cm_val;
   logic [5:0] cm_id;
   logic redirect, flush, q_avail_1, q_avail_2;
   logic [31:0] redirect_pc, flush_pc, q_val_1, q_val_2;
   int nvec = 0, miscompares = 0;

   rob_mc #(.DEPTH_LOG(3), .COMMIT_W(2)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_id(iss_id), .iss_type(iss_type),
      .iss_rd(iss_rd), .iss_done(iss_done), .iss_result(iss_result), .iss_pred_jmp(iss_pred_jmp),
      .iss_alt_pc(iss_alt_pc), .wb0_valid(wb0_valid), .wb0_id(wb0_id), .wb0_val(wb0_val),
      .wb0_redir_valid(wb0_redir_valid), .wb0_redir_pc(wb0_redir_pc), .wb1_valid(wb1_valid),
      .wb1_id(wb1_id), .wb1_val(wb1_val), .head_id(head_id), .count(count), .cm_en(cm_en),
      .cm_rd(cm_rd), .cm_val(cm_val), .cm_id(cm_id), .redirect(redirect), .redirect_pc(redirect_pc),
      .flush(flush), .flush_pc(flush_pc), .q_id_1(q_id_1), .q_id_2(q_id_2), .q_avail_1(q_avail_1),
      .q_avail_2(q_avail_2), .q_val_1(q_val_1), .q_val_2(q_val_2)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int iv, ityp, idone, ird, ires, w0v, w0id, w0val, w1v, w1id, w1val, q1;
      int ready, iid, head, cnt, cm, cmv0, cmv1, qa, qv;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic clr();
      rst_in = 0; rdy_in = 1; iss_valid = 0; iss_type = 0; iss_rd = 0; iss_done = 0;
      iss_result = 0; iss_pred_jmp = 0; iss_alt_pc = 0; wb0_valid = 0; wb0_id = 0; wb0_val = 0;
      wb0_redir_valid = 0; wb0_redir_pc = 0; wb1_valid = 0; wb1_id = 0; wb1_val = 0;
      q_id_1 = 0; q_id_2 = 0;
   endtask

   task automatic issue(int t, int r, int d, int res, int p, int a);
      iss_valid = 1; iss_type = 2'(t); iss_rd = 5'(r); iss_done = d[0];
      iss_result = res; iss_pred_jmp = p[0]; iss_alt_pc = a;
   endtask

   task automatic nxt();
      @(negedge clk_in);
   endtask

   task automatic apply(vec_t r);
      clr();
      iss_valid = r.iv[0]; iss_type = 2'(r.ityp); iss_done = r.idone[0]; iss_rd = 5'(r.ird);
      iss_result = r.ires; wb0_valid = r.w0v[0]; wb0_id = 3'(r.w0id); wb0_val = r.w0val;
      wb1_valid = r.w1v[0]; wb1_id = 3'(r.w1id); wb1_val = r.w1val; q_id_1 = 3'(r.q1);
      #1;
      nvec++;
      chk("iss_ready", 32'(iss_ready), r.ready);
      chk("iss_id", 32'(iss_id), r.iid);
      chk("head_id", 32'(head_id), r.head);
      chk("count", 32'(count), r.cnt);
      chk("cm_en", 32'(cm_en), r.cm);
      if (r.cm[0]) chk("cm_val0", cm_val[31:0], r.cmv0);
      if (r.cm[1]) chk("cm_val1", cm_val[63:32], r.cmv1);
      chk("q_avail_1", 32'(q_avail_1), r.qa);
      if (r.qa != 0) chk("q_val_1", q_val_1, r.qv);
      chk("flush", 32'(flush), 0);
      chk("redirect", 32'(redirect), 0);
      nxt();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 8; i++) tbl.push_back('{1,2,0,i+1,0, 0,0,0, 0,0,0, 0, 1,i,0,i,0,0,0,0,0});
      tbl.push_back('{1,2,0,9,0, 1,0,'h100, 1,1,'h101, 1, 0,0,0,8,0,0,0,1,'h101});
      tbl.push_back('{1,2,0,9,0, 0,0,0, 0,0,0, 1, 0,0,0,8,3,'h100,'h101,1,'h101});
      tbl.push_back('{1,2,0,9,'h55, 0,0,0, 0,0,0, 0, 1,0,2,6,0,0,0,0,0});
      tbl.push_back('{0,0,0,0,0, 1,2,'h102, 1,3,'h103, 0, 1,1,2,7,0,0,0,0,0});
      tbl.push_back('{0,0,0,0,0, 1,4,'h104, 1,5,'h105, 3, 1,1,2,7,3,'h102,'h103,1,'h103});
      tbl.push_back('{0,0,0,0,0, 1,6,'h106, 0,0,0, 0, 1,1,4,5,3,'h104,'h105,0,0});
      tbl.push_back('{0,0,0,0,0, 0,0,0, 0,0,0, 6, 1,1,6,3,1,'h106,0,1,'h106});
      tbl.push_back('{0,0,0,0,0, 1,7,'h11, 1,0,'h22, 7, 1,1,7,2,0,0,0,1,'h11});
      tbl.push_back('{0,0,0,0,0, 0,0,0, 0,0,0, 0, 1,1,7,2,3,'h11,'h22,1,'h22});
      tbl.push_back('{1,2,0,3,0, 1,1,'h77, 0,0,0, 2, 1,1,1,0,0,0,0,0,0});
      tbl.push_back('{0,0,0,0,0, 0,0,0, 0,0,0, 1, 1,2,1,1,0,0,0,0,0});
      tbl.push_back('{0,0,0,0,0, 0,0,0, 1,1,'h78, 1, 1,2,1,1,0,0,0,1,'h78});
      tbl.push_back('{0,0,0,0,0, 0,0,0, 0,0,0, 1, 1,2,1,1,1,'h78,0,1,'h78});
      tbl.push_back('{0,0,0,0,0, 0,0,0, 0,0,0, 1, 1,2,2,0,0,0,0,0,0});
      clr();
      rst_in = 1;
      nxt();
      nxt();
      clr();
      #1;
      nvec++;
      chk("rst count", 32'(count), 0);
      chk("rst head", 32'(head_id), 0);
      chk("rst iss_ready", 32'(iss_ready), 1);
      chk("rst cm_en", 32'(cm_en), 0);
      chk("rst flush", 32'(flush), 0);
      chk("rst redirect", 32'(redirect), 0);
      chk("rst flush_pc", flush_pc, 0);
      chk("rst redirect_pc", redirect_pc, 0);
      foreach (tbl[i]) apply(tbl[i]);
      // mispredicted branch at id 2 with a done younger reg-write behind it
      clr(); issue(1, 0, 0, 0, 0, 'h1000); #1; nvec++; chk("br iss_id", 32'(iss_id), 2); nxt();
      clr(); issue(2, 5, 1, 'h33, 0, 0); nxt();
      clr(); wb0_valid = 1; wb0_id = 2; wb0_val = 1; nxt();
      clr(); #1; nvec++;
      chk("br commit cm_en", 32'(cm_en), 0);
      chk("br pre flush", 32'(flush), 0);
      nxt();
      clr(); issue(2, 6, 1, 'h66, 0, 0); #1; nvec++;
      chk("flush", 32'(flush), 1);
      chk("flush_pc", flush_pc, 'h1000);
      chk("flush cm_en", 32'(cm_en), 0);
      nxt();
      clr(); #1; nvec++;
      chk("post flush", 32'(flush), 0);
      chk("post flush count", 32'(count), 0);
      chk("post flush head", 32'(head_id), 0);
      chk("post flush tail", 32'(iss_id), 0);
      chk("post flush cm_en", 32'(cm_en), 0);
      nxt();
      // jalr commits alone and produces a redirect pulse
      clr(); issue(3, 1, 0, 0, 0, 0); nxt();
      clr(); issue(2, 2, 1, 'h44, 0, 0); nxt();
      clr(); wb0_valid = 1; wb0_id = 0; wb0_val = 8; wb0_redir_valid = 1; wb0_redir_pc = 'h2040; nxt();
      clr(); #1; nvec++;
      chk("jalr cm_en", 32'(cm_en), 1);
      chk("jalr cm_val", cm_val[31:0], 8);
      chk("jalr cm_rd", 32'(cm_rd[4:0]), 1);
      chk("jalr pre redirect", 32'(redirect), 0);
      nxt();
      clr(); #1; nvec++;
      chk("redirect", 32'(redirect), 1);
      chk("redirect_pc", redirect_pc, 'h2040);
      chk("after jalr cm_en", 32'(cm_en), 1);
      chk("after jalr cm_val", cm_val[31:0], 'h44);
      chk("after jalr head", 32'(head_id), 1);
      nxt();
      clr(); #1; nvec++;
      chk("redirect drop", 32'(redirect), 0);
      chk("after jalr count", 32'(count), 0);
      chk("after jalr head2", 32'(head_id), 2);
      nxt();
      // same-cycle write-back collision on id 4
      for (int i = 0; i < 3; i++) begin clr(); issue(0, 0, 0, 0, 0, 0); nxt(); end
      clr(); wb0_valid = 1; wb0_id = 4; wb0_val = 'hAA; wb1_valid = 1; wb1_id = 4; wb1_val = 'hBB;
      q_id_1 = 4; q_id_2 = 4; #1; nvec++;
      chk("coll q_avail_1", 32'(q_avail_1), 1);
      chk("coll q_val_1", q_val_1, 'hBB);
      chk("coll q_avail_2", 32'(q_avail_2), 1);
      chk("coll q_val_2", q_val_2, 'hBB);
      nxt();
      clr(); q_id_1 = 4; #1; nvec++;
      chk("stored q_val_1", q_val_1, 'hBB);
      chk("stored q_avail_1", 32'(q_avail_1), 1);
      chk("coll cm_en", 32'(cm_en), 0);
      chk("coll count", 32'(count), 3);
      nxt();
      // pending flush held across three stalled cycles
      clr(); rst_in = 1; nxt();
      clr(); issue(1, 0, 1, 0, 1, 'h3000); nxt();
      clr(); issue(2, 3, 1, 9, 0, 0); nxt();
      for (int i = 0; i < 3; i++) begin
         clr(); rdy_in = 0; issue(2, 4, 1, 5, 0, 0); #1; nvec++;
         chk("stall flush", 32'(flush), 1);
         chk("stall flush_pc", flush_pc, 'h3000);
         chk("stall head", 32'(head_id), 1);
         chk("stall count", 32'(count), 1);
         chk("stall cm_en", 32'(cm_en), 0);
         nxt();
      end
      clr(); #1; nvec++; chk("resume flush", 32'(flush), 1); nxt();
      clr(); #1; nvec++;
      chk("resume flush drop", 32'(flush), 0);
      chk("resume count", 32'(count), 0);
      chk("resume head", 32'(head_id), 0);
      chk("resume tail", 32'(iss_id), 0);
      nxt();
      // reset taken instead of the pending flush
      clr(); issue(1, 0, 1, 0, 1, 'h3000); nxt();
      clr(); issue(2, 3, 1, 9, 0, 0); nxt();
      clr(); rst_in = 1; #1; nvec++; chk("pre rst flush", 32'(flush), 1); nxt();
      clr(); #1; nvec++;
      chk("rst over flush", 32'(flush), 0);
      chk("rst over flush_pc", flush_pc, 0);
      chk("rst over count", 32'(count), 0);
      chk("rst over head", 32'(head_id), 0);
      chk("rst over iss_ready", 32'(iss_ready), 1);
      nxt();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
      $finish;
   end
endmodule
